plot_request_sink: RTL and testbench
====================================

# plot_request_sink

Receiving end of the pixel-plot interface driven by the sprite drawing blocks (x, y, writeEn per cycle). Buffers plot requests in a small FIFO, discards coordinates outside the 160x120 screen, and forwards surviving requests to the VGA adapter's write port with a valid/ready handshake. Keeps saturating statistics of clipped and dropped requests for debug on the DE2 LEDs.

## Interface

- DEPTH, 8, FIFO entries; power of two, at least 2
- COLOUR_W, 3, colour field width
- clk  in  1  system clock
- resetn  in  1  asynchronous reset, active-low
- in_x  in  8  requested pixel column
- in_y  in  7  requested pixel row
- in_colour  in  COLOUR_W  requested colour
- in_writeEn  in  1  plot request valid this cycle
- in_ready  out  1  sink can accept a request this cycle
- vga_x  out  8  column to adapter
- vga_y  out  7  row to adapter
- vga_colour  out  COLOUR_W  colour to adapter
- vga_plot  out  1  adapter write valid
- vga_ready  in  1  adapter accepts write this cycle
- clear_stats  in  1  synchronous clear of both counters
- clip_count  out  8  off-screen requests discarded, saturating
- drop_count  out  8  requests lost to a full FIFO, saturating

## Operation

- Accept: in_writeEn=1 and in_ready=1. in_ready = FIFO not full. It does not depend on vga_ready, so a full FIFO stays not-ready during a simultaneous pop.
- Clip check runs on accept: x>=160 or y>=120 means the request is not written, and clip_count increments. Boundary values: x=159 and y=119 are on-screen; x=160 and y=120 are clipped.
- Drop: in_writeEn=1 while in_ready=0 increments drop_count, and the request is lost. Drawing blocks have no back-pressure, so this is the only record of a lost request.
- Both counters saturate at 255. clear_stats zeroes them next edge and overrides an increment in the same cycle.
- Output stage: one register holding x/y/colour and a valid bit (vga_plot).
  - Loads from the FIFO head when empty, or when a transfer (vga_plot and vga_ready) happens this cycle.
  - Otherwise holds its contents unchanged while vga_ready=0.
  - Output order equals accept order; there is no reordering or merging.
- Output-register FSM, two states:
  - IDLE: vga_plot=0. Go to HOLD when the FIFO is non-empty (load head).
  - HOLD: vga_plot=1. On transfer, reload and stay in HOLD if the FIFO is non-empty, else go to IDLE. Without a transfer, stay in HOLD.
- Width rules: FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.

## Timing

- Reset (resetn low, asynchronous) drives:
  - all outputs to 0, except in_ready=1
  - FIFO empty, pointers 0, FSM IDLE, counters 0
- A request in flight during reset is discarded. Release is synchronous to the next clk edge.
- Latency on an empty pipeline: request accepted at edge N, then vga_plot=1 with its data after edge N+1.
- Sustained throughput: 1 request/cycle when vga_ready is held at 1.
- Total capacity: DEPTH+1 requests (FIFO plus output register).
- Counter updates are visible the cycle after the causing event.
- vga_* outputs are registered with no combinational path from inputs. in_ready is a registered full flag.

## Structure

- Shared package:
  - SCREEN_W=160, SCREEN_H=120
  - the x/y widths (8/7)
  - a plot_req typedef {x, y, colour}
  - the FSM state enum
- Sub-module sync_fifo (parameters DEPTH, WIDTH): push/pop/full/empty/head.
- Clip logic, counters and output FSM live in plot_request_sink.

## Test plan

- Single request x=81,y=60,colour=3 after reset: vga_plot rises one cycle after accept with vga_x=81, vga_y=60, vga_colour=3. It drops after one vga_ready cycle.
- Clip boundaries: requests (159,119), (160,0), (0,120), (255,127) give exactly one forwarded pixel (159,119) and clip_count=3.
- Back-pressure: vga_ready=0, 12 back-to-back requests with DEPTH=8. Required: in_ready falls after 9 accepts, drop_count=3, outputs held stable. Releasing vga_ready then delivers 9 pixels in order, one per cycle.
- Saturation/clear: 300 off-screen requests leave clip_count=255. clear_stats pulsed on the same cycle as another clipped request leaves clip_count=0.
- Reset mid-burst: assert resetn low with 5 entries queued and vga_plot=1. Required: vga_plot=0 immediately (asynchronous), in_ready=1, and no stale pixel appears after release.
- Alternating vga_ready 1/0 with a continuous request stream: no loss, order preserved, occupancy never exceeds DEPTH.

Source files
------------

// File: rtl/plot_request_sink_pkg.sv
// Shared types and constants for the pixel-plot request sink: screen geometry,
// request record, output-stage state encoding and small arithmetic helpers.
package plot_request_sink_pkg;

   localparam int X_W           = 8;
   localparam int Y_W           = 7;
   localparam int PLOT_COLOUR_W = 3;
   localparam int CNT_W         = 8;

   localparam logic [X_W-1:0] SCREEN_W = 8'd160;
   localparam logic [Y_W-1:0] SCREEN_H = 7'd120;

   typedef struct packed {
      logic [X_W-1:0]           x;
      logic [Y_W-1:0]           y;
      logic [PLOT_COLOUR_W-1:0] colour;
   } plot_req_t;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } out_state_e;

   function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (x < SCREEN_W) && (y < SCREEN_H);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/plot_request_sink_sync_fifo.sv
// Single-clock FIFO with a registered full flag; head shows the oldest entry.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1'b1);
   localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(1'b0);
   localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic [AW:0]      count_nxt_s;
   logic             full_r;
   logic             push_s;
   logic             pop_s;

   assign push_s = push && !full_r;
   assign pop_s  = pop && (count_r != CNT_ZERO);

   // Occupancy update; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy and full flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= CNT_ZERO;
         full_r   <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CNT_DEPTH);
      end
   end

   // Storage array, not reset.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= din;
   end

   assign full  = full_r;
   assign empty = (count_r == CNT_ZERO);
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/plot_request_sink.sv
// Pixel-plot sink: buffers draw requests, discards off-screen ones, and feeds
// the VGA adapter through a registered valid/ready stage with debug counters.
module plot_request_sink
   import plot_request_sink_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int COLOUR_W = PLOT_COLOUR_W
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [X_W-1:0]      in_x,
   input  logic [Y_W-1:0]      in_y,
   input  logic [COLOUR_W-1:0] in_colour,
   input  logic                in_writeEn,
   output logic                in_ready,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   input  logic                vga_ready,
   input  logic                clear_stats,
   output logic [CNT_W-1:0]    clip_count,
   output logic [CNT_W-1:0]    drop_count
);

   plot_req_t        req_s;
   plot_req_t        head_s;
   plot_req_t        out_r;
   out_state_e       state_r;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             accept_s;
   logic             push_s;
   logic             clip_ev_s;
   logic             drop_ev_s;
   logic             load_s;
   logic             pop_s;
   logic [CNT_W-1:0] clip_cnt_r;
   logic [CNT_W-1:0] drop_cnt_r;

   assign req_s     = {in_x, in_y, in_colour};
   assign accept_s  = in_writeEn && !fifo_full_s;
   assign push_s    = accept_s && on_screen(in_x, in_y);
   assign clip_ev_s = accept_s && !on_screen(in_x, in_y);
   assign drop_ev_s = in_writeEn && fifo_full_s;

   // The output register may take a new entry when it is empty or is being drained.
   assign load_s = (state_r == ST_IDLE) || vga_ready;
   assign pop_s  = load_s && !fifo_empty_s;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(plot_req_t))
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push_s),
      .pop    (pop_s),
      .din    (req_s),
      .full   (fifo_full_s),
      .empty  (fifo_empty_s),
      .head   (head_s)
   );

   // Output-stage FSM and data register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         out_r   <= '{x: 8'd0, y: 7'd0, colour: 3'd0};
      end else if (load_s) begin
         if (!fifo_empty_s) begin
            state_r <= ST_HOLD;
            out_r   <= head_s;
         end else begin
            state_r <= ST_IDLE;
         end
      end
   end

   // Saturating debug counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clip_cnt_r <= 8'd0;
         drop_cnt_r <= 8'd0;
      end else if (clear_stats) begin
         clip_cnt_r <= 8'd0;
         drop_cnt_r <= 8'd0;
      end else begin
         if (clip_ev_s) clip_cnt_r <= sat_inc(clip_cnt_r);
         if (drop_ev_s) drop_cnt_r <= sat_inc(drop_cnt_r);
      end
   end

   assign in_ready   = !fifo_full_s;
   assign vga_plot   = (state_r == ST_HOLD);
   assign vga_x      = out_r.x;
   assign vga_y      = out_r.y;
   assign vga_colour = out_r.colour;
   assign clip_count = clip_cnt_r;
   assign drop_count = drop_cnt_r;

endmodule

// File: tb/tb_plot_request_sink.sv
// Directed bench for plot_request_sink: a clip-boundary vector table plus
// hand-written sequences for latency, back-pressure, saturation and reset.
module tb_plot_request_sink;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] in_x;
   logic [6:0] in_y;
   logic [2:0] in_colour;
   logic       in_writeEn;
   logic       in_ready;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       vga_ready;
   logic       clear_stats;
   logic [7:0] clip_count;
   logic [7:0] drop_count;

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         exp_clip;
   } vec_t;

   pix_t got[$];
   vec_t vec[4];
   int   checks = 0;
   int   errors = 0;
   int   accepts;

   plot_request_sink #(.DEPTH(8), .COLOUR_W(3)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_colour   (in_colour),
      .in_writeEn  (in_writeEn),
      .in_ready    (in_ready),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .vga_ready   (vga_ready),
      .clear_stats (clear_stats),
      .clip_count  (clip_count),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   // Record every pixel that will transfer on the coming rising edge.
   always @(negedge clk) begin
      if (resetn && vga_plot && vga_ready)
         got.push_back('{x: int'(vga_x), y: int'(vga_y), c: int'(vga_colour)});
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int x, input int y, input int c);
      in_x       = 8'(x);
      in_y       = 7'(y);
      in_colour  = 3'(c);
      in_writeEn = 1'b1;
   endtask

   initial begin
      vec[0] = '{x: 8'd159, y: 7'd119, c: 3'd5, exp_clip: 0};
      vec[1] = '{x: 8'd160, y: 7'd0,   c: 3'd1, exp_clip: 1};
      vec[2] = '{x: 8'd0,   y: 7'd120, c: 3'd2, exp_clip: 2};
      vec[3] = '{x: 8'd255, y: 7'd127, c: 3'd7, exp_clip: 3};

      resetn = 1'b0; in_x = 8'd0; in_y = 7'd0; in_colour = 3'd0;
      in_writeEn = 1'b0; vga_ready = 1'b0; clear_stats = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Reset state
      chk("rst_in_ready", in_ready, 1);
      chk("rst_vga_plot", vga_plot, 0);
      chk("rst_vga_x", vga_x, 0);
      chk("rst_clip", clip_count, 0);
      chk("rst_drop", drop_count, 0);

      // Single request latency
      req(81, 60, 3);
      step();
      in_writeEn = 1'b0;
      chk("lat_plot_early", vga_plot, 0);
      step();
      chk("lat_plot", vga_plot, 1);
      chk("lat_x", vga_x, 81);
      chk("lat_y", vga_y, 60);
      chk("lat_colour", vga_colour, 3);
      vga_ready = 1'b1;
      step();
      chk("lat_plot_drop", vga_plot, 0);
      got.delete();

      // Clip boundaries from the vector table
      for (int i = 0; i < 4; i++) begin
         req(int'(vec[i].x), int'(vec[i].y), int'(vec[i].c));
         step();
         chk($sformatf("clip_vec%0d", i), clip_count, vec[i].exp_clip);
      end
      in_writeEn = 1'b0;
      repeat (3) step();
      chk("clip_fwd_n", got.size(), 1);
      if (got.size() >= 1) begin
         chk("clip_fwd_x", got[0].x, 159);
         chk("clip_fwd_y", got[0].y, 119);
         chk("clip_fwd_c", got[0].c, 5);
      end

      // Back-pressure: 12 requests into DEPTH+1 capacity
      vga_ready = 1'b0;
      got.delete();
      accepts = 0;
      for (int i = 0; i < 12; i++) begin
         req(10 + i, i, i);
         if (in_ready) accepts++;
         step();
      end
      in_writeEn = 1'b0;
      chk("bp_accepts", accepts, 9);
      chk("bp_drop", drop_count, 3);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_plot", vga_plot, 1);
      chk("bp_hold_x", vga_x, 10);
      step();
      chk("bp_hold_x2", vga_x, 10);
      vga_ready = 1'b1;
      repeat (9) step();
      chk("bp_plot_done", vga_plot, 0);
      chk("bp_fwd_n", got.size(), 9);
      for (int i = 0; i < got.size() && i < 9; i++) begin
         chk($sformatf("bp_order_x%0d", i), got[i].x, 10 + i);
         chk($sformatf("bp_order_y%0d", i), got[i].y, i);
      end

      // Saturation and clear priority
      for (int i = 0; i < 300; i++) begin
         req(200, 5, 0);
         step();
      end
      chk("sat_clip", clip_count, 255);
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      in_writeEn  = 1'b0;
      chk("clr_clip", clip_count, 0);
      chk("clr_drop", drop_count, 0);
      step();
      chk("clr_hold", clip_count, 0);

      // Reset mid-burst
      vga_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req(50 + i, 40, 1);
         step();
      end
      in_writeEn = 1'b0;
      chk("mid_plot_before", vga_plot, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_plot_async", vga_plot, 0);
      chk("mid_in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      got.delete();
      vga_ready = 1'b1;
      repeat (6) step();
      chk("mid_no_stale_n", got.size(), 0);
      chk("mid_no_stale_plot", vga_plot, 0);

      // Alternating vga_ready with a continuous stream
      got.delete();
      for (int i = 0; i < 12; i++) begin
         req(100 + i, 20 + i, i);
         vga_ready = (i % 2 == 0);
         step();
      end
      in_writeEn = 1'b0;
      vga_ready  = 1'b1;
      repeat (12) step();
      chk("alt_drop", drop_count, 0);
      chk("alt_n", got.size(), 12);
      for (int i = 0; i < got.size() && i < 12; i++) begin
         chk($sformatf("alt_x%0d", i), got[i].x, 100 + i);
         chk($sformatf("alt_y%0d", i), got[i].y, 20 + i);
         chk($sformatf("alt_c%0d", i), got[i].c, i % 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
